// File: rtl/div_e_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_e_if
//  Description : Handshake/operand bundle between the E-stage control logic
//                (master) and the sequential divider (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface div_e_if;
  logic        flush;       // E-stage flush, cancels any operation
  logic        start;       // DIV/DIVU present in E, not yet issued
  logic        signed_div;  // 1 = DIV, 0 = DIVU
  logic [31:0] opa;         // dividend
  logic [31:0] opb;         // divisor
  logic        busy;        // stall request to the hazard unit
  logic        done;        // one-cycle result-valid pulse
  logic [63:0] hilores;     // {hi = remainder, lo = quotient}

  // E-stage side: issues operations, consumes the result
  modport master (
    output flush, start, signed_div, opa, opb,
    input  busy, done, hilores
  );

  // Divider side
  modport slave (
    input  flush, start, signed_div, opa, opb,
    output busy, done, hilores
  );
endinterface
`default_nettype wire

// File: rtl/div_e.sv
`default_nettype none
// ============================================================================
//  Module      : div_e
//  Description : 32-bit radix-2 restoring divider for MIPS DIV/DIVU in the
//                execute stage. One quotient bit per cycle, 64-bit
//                {remainder, quotient} result, combinational stall request.
//  Revision    : 1.0  initial release
// ============================================================================
module div_e (
  input  logic    clk,
  input  logic    reset,
  div_e_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;      // partial remainder
  logic [31:0] r_quo;      // dividend bits shift out the top, quotient bits in
  logic [31:0] r_dvs;      // divisor magnitude
  logic        r_qneg;     // quotient must be negated at the end
  logic        r_rneg;     // remainder must be negated at the end
  logic        r_done;
  logic [63:0] r_hilores;

  // Operand magnitudes; only DIV treats the operands as two's complement
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_launch;

  assign w_a_neg  = bus.signed_div & bus.opa[31];
  assign w_b_neg  = bus.signed_div & bus.opb[31];
  assign w_abs_a  = w_a_neg ? (32'd0 - bus.opa) : bus.opa;
  assign w_abs_b  = w_b_neg ? (32'd0 - bus.opb) : bus.opb;
  assign w_launch = (r_state == S_IDLE) & bus.start & ~bus.flush;

  // One restoring step: the 33-bit trial borrows exactly when the shifted
  // remainder is smaller than the divisor, so bit 32 is the restore flag.
  logic [32:0] w_shift_rem;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_out;
  logic [31:0] w_r_out;

  assign w_shift_rem = {r_rem, r_quo[31]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvs};
  assign w_qbit      = ~w_trial[32];
  assign w_rem_next  = w_qbit ? w_trial[31:0] : w_shift_rem[31:0];
  assign w_quo_next  = {r_quo[30:0], w_qbit};

  // Sign correction of the final step, all mod 2^32
  assign w_q_out = r_qneg ? (32'd0 - w_quo_next) : w_quo_next;
  assign w_r_out = r_rneg ? (32'd0 - w_rem_next) : w_rem_next;

  // Stall starts in the same cycle as start; DONE lets E advance
  assign bus.busy    = w_launch | (r_state == S_CALC);
  assign bus.done    = r_done;
  assign bus.hilores = r_hilores;

  // Controller and datapath: launch, iterate, register signed result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_dvs     <= 32'd0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_done    <= 1'b0;
      r_hilores <= 64'd0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem  <= 32'd0;
            r_cnt  <= 5'd0;
            r_quo  <= w_abs_a;
            r_dvs  <= w_abs_b;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            if (bus.opb == 32'd0) begin
              // Divide by zero skips the iterations entirely
              r_hilores <= {bus.opa, 32'hFFFF_FFFF};
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_hilores <= {w_r_out, w_q_out};
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_e.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_e
//  Description : Directed self-checking bench for div_e.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_e;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  int   done_cyc;

  div_e_if bus ();

  div_e u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide with start held until done; checks latency, busy
  // length, busy low in DONE, and the result.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp, input int exp_lat,
                         input bit scramble);
    int c;
    int nbusy;
    bit seen;
    @(posedge clk); #1;
    bus.opa = a; bus.opb = b; bus.signed_div = sg; bus.start = 1'b1;
    c = 0; nbusy = 0; seen = 1'b0;
    #1;
    while (c < 100 && !seen) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy === 1'b1) nbusy++;
        @(posedge clk); #1;
        if (scramble) begin
          bus.opa = $urandom; bus.opb = $urandom; bus.signed_div = 1'($urandom);
        end
        #1;
        c++;
      end
    end
    done_cyc = cyc;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(c), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hilores"}, bus.hilores, exp);
    bus.start = 1'b0;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    bit any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) any = 1'b1;
    end
    chk(tag, 64'(any), 64'd0);
  endtask

  initial begin
    int d1;
    errors = 0; checks = 0; cyc = 0; done_cyc = 0;
    reset = 1'b1;
    bus.flush = 1'b0; bus.start = 1'b0; bus.signed_div = 1'b0;
    bus.opa = 32'd0; bus.opb = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilores", bus.hilores, 64'd0);

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0);
    run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b0);
    run_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0);
    run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 1'b0);
    run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 1, 1'b0);
    run_div("div_m5_0", 32'hFFFFFFFB, 32'd0, 1'b1, 64'hFFFFFFFB_FFFFFFFF, 1, 1'b0);

    // Flush ten cycles into 1000 / 3
    @(posedge clk); #1;
    bus.opa = 32'd1000; bus.opb = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_hilores", bus.hilores, 64'hFFFFFFFB_FFFFFFFF);
    run_div("after_flush_9_4", 32'd9, 32'd4, 1'b0, 64'h00000001_00000002, 33, 1'b0);

    // start and flush together must not launch
    @(posedge clk); #1;
    bus.opa = 32'd50; bus.opb = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    chk("startflush_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    chk("startflush_busy_after", 64'(bus.busy), 64'd0);
    watch_no_done("startflush_idle", 40);
    chk("startflush_hilores", bus.hilores, 64'h00000001_00000002);

    // Operand changes during CALC must not matter
    run_div("scramble_1000_3", 32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33, 1'b1);

    // Back-to-back DIVU
    run_div("b2b_10_3", 32'd10, 32'd3, 1'b0, 64'h00000001_00000003, 33, 1'b0);
    d1 = done_cyc;
    run_div("b2b_20_6", 32'd20, 32'd6, 1'b0, 64'h00000002_00000003, 33, 1'b0);
    chk("b2b_spacing", 64'(done_cyc - d1), 64'd34);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    bus.opa = 32'd100; bus.opb = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_hilores", bus.hilores, 64'd0);
    watch_no_done("midreset_no_done", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
